// File: rtl/conv_pkg.sv
// Shared defaults, address-width helper and FSM state encoding for the
// convolution window sequencer.
package conv_pkg;

  localparam int DEF_K     = 3;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;

  function automatic int addr_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  localparam int DEF_ADDR_W = addr_width(DEF_IMG_W, DEF_IMG_H);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_DRAIN1 = 3'd2,
    ST_DRAIN2 = 3'd3,
    ST_DUMP   = 3'd4,
    ST_CLEAR  = 3'd5
  } state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Tap (kx, ky) and window (r, c) counters plus pixel/weight address generation
// for a stride-1, unpadded KxK scan.
module window_addr_gen
  import conv_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tap_step,
  input  logic                       win_step,
  output logic [ADDR_W-1:0]          pix_addr,
  output logic [$clog2(K*K)-1:0]     w_addr,
  output logic [$clog2(IMG_H)-1:0]   row,
  output logic [$clog2(IMG_W)-1:0]   col,
  output logic                       last_tap,
  output logic                       last_win
);

  localparam int KC_W = $clog2(K + 1);
  localparam int WA_W = $clog2(K * K);
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);

  localparam logic [KC_W-1:0] K_MAX = KC_W'(K - 1);
  localparam logic [RW-1:0]   R_MAX = RW'(IMG_H - K);
  localparam logic [CW-1:0]   C_MAX = CW'(IMG_W - K);

  logic [KC_W-1:0]   kx;
  logic [KC_W-1:0]   ky;
  logic [RW-1:0]     r;
  logic [CW-1:0]     c;
  logic [ADDR_W-1:0] pix_row;
  logic [ADDR_W-1:0] pix_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      kx <= '0;
      ky <= '0;
    end else if (tap_step) begin
      if (kx == K_MAX) begin
        kx <= '0;
        ky <= (ky == K_MAX) ? '0 : ky + 1'b1;
      end else begin
        kx <= kx + 1'b1;
      end
    end
  end

  // Window origin wraps back to (0,0) after the last window so the next scan starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      c <= '0;
    end else if (win_step) begin
      if (c == C_MAX) begin
        c <= '0;
        r <= (r == R_MAX) ? '0 : r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end

  assign pix_row  = ADDR_W'(r) + ADDR_W'(ky);
  assign pix_col  = ADDR_W'(c) + ADDR_W'(kx);
  assign pix_addr = pix_row * ADDR_W'(IMG_W) + pix_col;
  assign w_addr   = WA_W'(ky) * WA_W'(K) + WA_W'(kx);

  assign row      = r;
  assign col      = c;
  assign last_tap = (kx == K_MAX) && (ky == K_MAX);
  assign last_win = (r == R_MAX) && (c == C_MAX);

endmodule

// File: rtl/conv_window_sequencer.sv
// Sliding-window scan controller feeding one mac_generic: issues memory reads
// and lines up en_MAC / en_MAC_out / clr with the MAC's two-stage pipeline.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int I_W    = 8,
  parameter int K      = DEF_K,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [ADDR_W-1:0]          pix_addr,
  output logic [$clog2(K*K)-1:0]     w_addr,
  output logic                       rd_en,
  input  logic [I_W-1:0]             pix_rdata,
  input  logic [I_W-1:0]             w_rdata,
  output logic [I_W-1:0]             A,
  output logic [I_W-1:0]             B,
  output logic                       en_MAC,
  output logic                       en_MAC_out,
  output logic                       clr,
  output logic                       out_valid,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       busy,
  output logic                       done
);

  state_t state;
  state_t state_nxt;

  logic                     last_tap;
  logic                     last_win;
  logic [$clog2(IMG_H)-1:0] row;
  logic [$clog2(IMG_W)-1:0] col;

  window_addr_gen #(
    .K      (K),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .tap_step (rd_en),
    .win_step (out_valid),
    .pix_addr (pix_addr),
    .w_addr   (w_addr),
    .row      (row),
    .col      (col),
    .last_tap (last_tap),
    .last_win (last_win)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Read data returns one cycle after rd_en, so en_MAC is simply rd_en delayed.
  always_ff @(posedge clk) begin
    if (rst) en_MAC <= 1'b0;
    else     en_MAC <= rd_en;
  end

  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    en_MAC_out = 1'b0;
    clr        = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        rd_en = 1'b1;
        if (last_tap) state_nxt = ST_DRAIN1;
      end
      ST_DRAIN1: state_nxt = ST_DRAIN2;
      ST_DRAIN2: state_nxt = ST_DUMP;
      ST_DUMP: begin
        en_MAC_out = 1'b1;
        state_nxt  = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr       = 1'b1;
        out_valid = 1'b1;
        if (last_win) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign busy    = (state != ST_IDLE);
  assign out_row = out_valid ? row : '0;
  assign out_col = out_valid ? col : '0;
  assign A       = pix_rdata;
  assign B       = w_rdata;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: a reference model fills address and
// window-result queues at start; a monitor pops them as the DUT emits rd_en/out_valid.
module tb_conv_window_sequencer;

  localparam int I_W    = 8;
  localparam int K      = 3;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int ADDR_W = 10;
  localparam int N_WIN  = (IMG_H - K + 1) * (IMG_W - K + 1);
  localparam int PERIOD = K * K + 4;

  typedef struct {
    int pix;
    int w;
  } tap_t;

  typedef struct {
    int row;
    int col;
    int sum;
    int last;
    int cyc;
  } win_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic [ADDR_W-1:0]        pix_addr;
  logic [$clog2(K*K)-1:0]   w_addr;
  logic                     rd_en;
  logic [I_W-1:0]           pix_rdata = '0;
  logic [I_W-1:0]           w_rdata = '0;
  logic [I_W-1:0]           A;
  logic [I_W-1:0]           B;
  logic                     en_MAC;
  logic                     en_MAC_out;
  logic                     clr;
  logic                     out_valid;
  logic [$clog2(IMG_H)-1:0] out_row;
  logic [$clog2(IMG_W)-1:0] out_col;
  logic                     busy;
  logic                     done;

  int pix_val [IMG_H*IMG_W];
  int w_val   [K*K];
  tap_t addr_q[$];
  win_t exp_q[$];

  int cyc = 0;
  int y_model = 0;
  int check_cnt = 0;
  int pass_cnt = 0;
  int pulse_cnt = 0;
  int last_done_cyc = -10;
  bit prev_en_out = 1'b0;

  conv_window_sequencer #(
    .I_W    (I_W),
    .K      (K),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_addr   (pix_addr),
    .w_addr     (w_addr),
    .rd_en      (rd_en),
    .pix_rdata  (pix_rdata),
    .w_rdata    (w_rdata),
    .A          (A),
    .B          (B),
    .en_MAC     (en_MAC),
    .en_MAC_out (en_MAC_out),
    .clr        (clr),
    .out_valid  (out_valid),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories and a behavioural accumulator standing in for the MAC's Y.
  always @(posedge clk) begin
    if (rd_en) begin
      pix_rdata <= I_W'(pix_val[pix_addr]);
      w_rdata   <= I_W'(w_val[w_addr]);
    end
    if (rst || clr) y_model <= 0;
    else if (en_MAC) y_model <= y_model + $signed(A) * $signed(B);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pix_addr"}, int'(pix_addr), 0);
    checkOutput({tag, "_w_addr"}, int'(w_addr), 0);
    checkOutput({tag, "_rd_en"}, int'(rd_en), 0);
    checkOutput({tag, "_en_MAC"}, int'(en_MAC), 0);
    checkOutput({tag, "_en_MAC_out"}, int'(en_MAC_out), 0);
    checkOutput({tag, "_clr"}, int'(clr), 0);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_row"}, int'(out_row), 0);
    checkOutput({tag, "_out_col"}, int'(out_col), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a read or a result.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        if (addr_q.size() == 0) begin
          checkOutput("unexpected_rd_en", 1, 0);
        end else begin
          tap_t t;
          t = addr_q.pop_front();
          checkOutput("pix_addr", int'(pix_addr), t.pix);
          checkOutput("w_addr", int'(w_addr), t.w);
        end
      end
      if (clr) checkOutput("clr_overlap", int'(en_MAC || en_MAC_out), 0);
      if (out_valid) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 1, 0);
        end else begin
          win_t e;
          e = exp_q.pop_front();
          checkOutput("out_row", int'(out_row), e.row);
          checkOutput("out_col", int'(out_col), e.col);
          checkOutput("window_sum", y_model, e.sum);
          checkOutput("done_flag", int'(done), e.last);
          checkOutput("out_valid_cycle", cyc, e.cyc);
          checkOutput("en_MAC_out_before_clr", int'(prev_en_out), 1);
        end
        if (done) last_done_cyc = cyc;
      end else if (done) begin
        checkOutput("done_without_valid", 1, 0);
      end
      if (cyc == last_done_cyc + 1) checkOutput("busy_after_done", int'(busy), 0);
      prev_en_out = en_MAC_out;
    end
  end

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Fills the memories for a pattern, starts a scan and queues every expected read and result.
  task automatic applyStimulus(input int pattern, output int n);
    int widx = 0;
    for (int a = 0; a < IMG_H * IMG_W; a++) begin
      case (pattern)
        0:       pix_val[a] = 1;
        1:       pix_val[a] = a % 128;
        default: pix_val[a] = int'($urandom_range(0, 255)) - 128;
      endcase
    end
    for (int t = 0; t < K * K; t++)
      w_val[t] = (pattern == 2) ? int'($urandom_range(0, 255)) - 128 : 1;
    pulse_cnt = 0;
    pulseStart();
    n = cyc;
    for (int r = 0; r <= IMG_H - K; r++) begin
      for (int c = 0; c <= IMG_W - K; c++) begin
        win_t e;
        int s = 0;
        for (int ky = 0; ky < K; ky++) begin
          for (int kx = 0; kx < K; kx++) begin
            tap_t t;
            t.pix = (r + ky) * IMG_W + (c + kx);
            t.w   = ky * K + kx;
            addr_q.push_back(t);
            s += pix_val[t.pix] * w_val[t.w];
          end
        end
        e.row  = r;
        e.col  = c;
        e.sum  = s;
        e.last = (widx == N_WIN - 1) ? 1 : 0;
        e.cyc  = n + K * K + 3 + PERIOD * widx;
        exp_q.push_back(e);
        widx++;
      end
    end
  endtask

  task automatic waitScan(input string tag);
    int budget = 0;
    int limit = N_WIN * PERIOD + 100;
    while ((busy || exp_q.size() != 0) && budget < limit) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({tag, "_timeout"}, int'(budget < limit), 1);
    checkOutput({tag, "_pulses"}, pulse_cnt, N_WIN);
    checkOutput({tag, "_reads_left"}, addr_q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");

    // Ramp pattern, aborted by rst during cycle 5 of window 3.
    applyStimulus(1, n);
    while (cyc < n + 3 * PERIOD + 5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("pulses_before_rst", pulse_cnt, 3);
    addr_q.delete();
    exp_q.delete();
    @(negedge clk);
    checkResetState("midscan_rst");
    repeat (20) @(posedge clk);

    // All-ones scan with start pulses while busy that must be ignored.
    applyStimulus(0, n);
    repeat (40) @(posedge clk);
    pulseStart();
    repeat (300) @(posedge clk);
    pulseStart();
    waitScan("ones");

    applyStimulus(1, n);
    waitScan("ramp");

    applyStimulus(2, n);
    waitScan("random");

    @(negedge clk);
    checkOutput("idle_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Upstream control stage for `mac_generic`: scans a stored IMG_H×IMG_W feature map with a K×K sliding window (stride 1, no padding) and drives the MAC's operand and control inputs. It issues pixel and weight memory reads, aligns `en_MAC`, `en_MAC_out` and `clr` to the MAC's 2-stage multiply/accumulate pipeline, and flags the cycle in which the MAC output `Y` holds a finished window sum. One instance feeds one `mac_generic`.

## Interface
- `I_W`, 8, operand width (matches MAC `I_W`)
- `K`, 3, kernel size
- `IMG_W`, 28, feature-map width
- `IMG_H`, 28, feature-map height
- `ADDR_W`, 10, pixel address width, ≥ clog2(IMG_W*IMG_H)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a full-map scan when idle
- `pix_addr`  out  ADDR_W  feature-memory read address
- `w_addr`  out  clog2(K*K)  weight-memory read address
- `rd_en`  out  1  read strobe to both memories (1-cycle synchronous read latency)
- `pix_rdata`  in  I_W  signed pixel data, valid the cycle after `rd_en`
- `w_rdata`  in  I_W  signed weight data, valid the cycle after `rd_en`
- `A`, `B`  out  I_W  MAC operands; combinational pass-through of `pix_rdata`, `w_rdata`
- `en_MAC`, `en_MAC_out`, `clr`  out  1  MAC control
- `out_valid`  out  1  `Y` of the MAC holds a complete window sum this cycle
- `out_row`, `out_col`  out  clog2(IMG_H), clog2(IMG_W)  output coordinate for `out_valid`
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse coincident with the final `out_valid`

## Operation
- FSM: IDLE → ISSUE (K² cycles) → DRAIN1 → DRAIN2 → DUMP → CLEAR → ISSUE (next window) or IDLE (last window).
- IDLE: all control outputs 0; `start`=1 → ISSUE, `busy`=1. `start` outside IDLE ignored.
- ISSUE: `rd_en`=1; tap counters kx (inner), ky (outer); `pix_addr`=(r+ky)*IMG_W+(c+kx), `w_addr`=ky*K+kx.
- `en_MAC` = `rd_en` delayed one register → high exactly K² cycles, aligned with returned data.
- DUMP: `en_MAC_out`=1. CLEAR: `clr`=1, `out_valid`=1, `out_row`=r, `out_col`=c; then window counters advance: c+1; at c=IMG_W-K, c←0, r+1; at r=IMG_H-K and c=IMG_W-K, `done`=1 and next state IDLE.
- `clr` never coincides with `en_MAC` or `en_MAC_out`.
- Address arithmetic unsigned, no overflow for legal parameters; counters never exceed their window limits.

## Timing
- Reset: state IDLE; `pix_addr`, `w_addr`, `rd_en`, `en_MAC`, `en_MAC_out`, `clr`, `out_valid`, `out_row`, `out_col`, `busy`, `done` all 0; counters 0.
- Cycle 0 = first ISSUE cycle (cycle after `start` sampled). `rd_en` cycles 0..K²-1; `en_MAC` 1..K²; `en_MAC_out` K²+2; `clr`/`out_valid` K²+3; next ISSUE K²+4.
- Window period K²+4 (13 for K=3); full scan (IMG_H-K+1)(IMG_W-K+1)(K²+4) cycles (8788 default).
- `out_valid` lasts one cycle; consumer samples `Y` at its end (MAC clears `Y` on that edge).
- `rst` mid-scan: next cycle IDLE with reset values; no `done`; MAC cleared by `rst` path or next `clr`.
- `busy` falls the cycle after `done`; `start` in that cycle is accepted.

## Structure
- Package `conv_pkg`: default K/IMG_W/IMG_H, ADDR_W clog2 helper, FSM state encoding constants.
- One sub-module `window_addr_gen`: kx/ky/c/r counters, address computation, last-tap/last-window flags; FSM stays in the top.

## Test plan
- All pixels=1, weights=1, K=3: `start` → first `out_valid` at cycle 12, MAC `Y`=9, `out_row`=0, `out_col`=0.
- Pixel[a]=a mod 128, weights=1: first window `pix_addr` sequence 0,1,2,28,29,30,56,57,58, `w_addr` 0..8; `Y`=261.
- Row wrap: window (0,25) reads 25,26,27,53,…; next window (1,0) reads starting at 28; `out_col` 25→0, `out_row` 0→1.
- Full scan: exactly 676 `out_valid` pulses 13 cycles apart; `done` with the 676th; `busy` low next cycle.
- `rst` at cycle 5 of window 3 → all outputs 0 next cycle, no `out_valid`; fresh `start` restarts at (0,0) with `Y`=9.
- `start` pulsed while `busy` → no effect on address sequence or pulse count.
